// File: rtl/traffic_pkg.sv
// Shared types and default constants for the traffic light controller family.
package traffic_pkg;

   // Light encodings used by the controller that consumes the phase timer.
   typedef enum logic [1:0] {
      RED    = 2'b00,
      YELLOW = 2'b01,
      GREEN  = 2'b10
   } light_t;

   // Power-on phase durations in seconds and default time base.
   localparam int unsigned GREEN_DEF_SEC  = 32'd5;
   localparam int unsigned YELLOW_DEF_SEC = 32'd1;
   localparam int unsigned TICK_DIV_DEF   = 32'd50000000;
   localparam int unsigned CNT_W_DEF      = 32'd8;

   // Duration-update handshake states.
   typedef enum logic {
      CFG_IDLE = 1'b0,
      CFG_PEND = 1'b1
   } cfg_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into a one-cycle sec_tick every TICK_DIV cycles.
// hold freezes the divider; clear restarts it and suppresses any coincident tick.
module tick_prescaler #(
   parameter int unsigned TICK_DIV = 32'd50000000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic hold,
   input  logic clear,
   output logic wrap,
   output logic sec_tick
);

   localparam int unsigned       DIV_W    = $clog2(TICK_DIV);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 32'd1);

   logic [DIV_W-1:0] div_cnt_q;
   logic [DIV_W-1:0] div_cnt_d;
   logic             sec_tick_q;

   // Wrap happens on the last divider count unless frozen or being cleared.
   always_comb begin
      wrap = 1'b0;
      if (!clear && !hold && (div_cnt_q == DIV_LAST)) begin
         wrap = 1'b1;
      end else begin
         wrap = 1'b0;
      end
   end

   // Next divider value: clear wins, then hold, then wrap, else count up.
   always_comb begin
      div_cnt_d = div_cnt_q;
      if (clear) begin
         div_cnt_d = {DIV_W{1'b0}};
      end else if (hold) begin
         div_cnt_d = div_cnt_q;
      end else if (wrap) begin
         div_cnt_d = {DIV_W{1'b0}};
      end else begin
         div_cnt_d = div_cnt_q + DIV_W'(1);
      end
   end

   // Divider state and registered tick pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt_q  <= {DIV_W{1'b0}};
         sec_tick_q <= 1'b0;
      end else begin
         div_cnt_q  <= div_cnt_d;
         sec_tick_q <= wrap;
      end
   end

   assign sec_tick = sec_tick_q;

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase timer: counts seconds in the current light phase and flags when the
// active green/yellow durations have elapsed. Durations are reprogrammed via a
// valid/ready port and only switch over on the next rst_count.
module traffic_phase_timer
   import traffic_pkg::*;
#(
   parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter int unsigned GREEN_DEF  = GREEN_DEF_SEC,
   parameter int unsigned YELLOW_DEF = YELLOW_DEF_SEC
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             rst_count,
   input  logic             hold,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_green,
   input  logic [CNT_W-1:0] cfg_yellow,
   output logic             one_sec_timer,
   output logic             five_sec_timer,
   output logic             sec_tick,
   output logic [CNT_W-1:0] elapsed
);

   localparam logic [CNT_W-1:0] ELAPSED_MAX = {CNT_W{1'b1}};

   // A zero duration would fire immediately at phase start; force at least 1 s.
   function automatic logic [CNT_W-1:0] clamp_dur(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b0}}) begin
         return CNT_W'(1);
      end else begin
         return v;
      end
   endfunction

   logic             wrap_s;
   logic [CNT_W-1:0] elapsed_q;
   logic [CNT_W-1:0] elapsed_d;
   cfg_state_t       cfg_state_q;
   logic             cfg_ready_q;
   logic [CNT_W-1:0] green_pend_q;
   logic [CNT_W-1:0] yellow_pend_q;
   logic [CNT_W-1:0] green_act_q;
   logic [CNT_W-1:0] yellow_act_q;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk      (clk),
      .reset_n  (reset_n),
      .hold     (hold),
      .clear    (rst_count),
      .wrap     (wrap_s),
      .sec_tick (sec_tick)
   );

   // Elapsed seconds: cleared by rst_count, otherwise saturating count on wrap.
   always_comb begin
      elapsed_d = elapsed_q;
      if (rst_count) begin
         elapsed_d = {CNT_W{1'b0}};
      end else if (wrap_s && (elapsed_q != ELAPSED_MAX)) begin
         elapsed_d = elapsed_q + CNT_W'(1);
      end else begin
         elapsed_d = elapsed_q;
      end
   end

   // Elapsed-seconds register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         elapsed_q <= {CNT_W{1'b0}};
      end else begin
         elapsed_q <= elapsed_d;
      end
   end

   // Config FSM: capture a request, then swap it in at the next phase boundary.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cfg_state_q   <= CFG_IDLE;
         cfg_ready_q   <= 1'b1;
         green_pend_q  <= CNT_W'(GREEN_DEF);
         yellow_pend_q <= CNT_W'(YELLOW_DEF);
         green_act_q   <= CNT_W'(GREEN_DEF);
         yellow_act_q  <= CNT_W'(YELLOW_DEF);
      end else begin
         case (cfg_state_q)
            CFG_IDLE: begin
               // A capture coincident with rst_count waits for the next boundary.
               if (cfg_valid && cfg_ready_q) begin
                  green_pend_q  <= clamp_dur(cfg_green);
                  yellow_pend_q <= clamp_dur(cfg_yellow);
                  cfg_state_q   <= CFG_PEND;
                  cfg_ready_q   <= 1'b0;
               end
            end
            CFG_PEND: begin
               if (rst_count) begin
                  green_act_q  <= green_pend_q;
                  yellow_act_q <= yellow_pend_q;
                  cfg_state_q  <= CFG_IDLE;
                  cfg_ready_q  <= 1'b1;
               end
            end
            default: begin
               cfg_state_q <= CFG_IDLE;
               cfg_ready_q <= 1'b1;
            end
         endcase
      end
   end

   // Expiry levels depend only on registered state.
   assign one_sec_timer  = (elapsed_q >= yellow_act_q);
   assign five_sec_timer = (elapsed_q >= green_act_q);
   assign elapsed        = elapsed_q;
   assign cfg_ready      = cfg_ready_q;

endmodule
